cv32e41p_fpu_arbiter: RTL
=========================

CV32E41P_FPU_ARBITER -- requirements
Module: cv32e41p_fpu_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters sharing one FPU (2..4).
REQ-002 SHALL have parameter MAX_OUTST, default 2, maximum FPU operations in flight (1..4).
REQ-003 SHALL have parameter WIDTH, default 32, operand and result width.
REQ-004 SHALL have ports clk, input, 1, clock; rst, input, 1, reset. One clock; reset is asynchronous and active-high.
REQ-005 SHALL have req_valid_i, input, NREQ, per-requester request valid.
REQ-006 SHALL have req_ready_o, output, NREQ, per-requester request accepted.
REQ-007 SHALL have req_op_i, input, NREQ x 4, operation_e code per requester.
REQ-008 SHALL have req_fmt_i, input, NREQ x 3, fp_format_e per requester.
REQ-009 SHALL have req_operands_i, input, NREQ x 3 x WIDTH, operands per requester.
REQ-010 SHALL have fpu_valid_o/fpu_ready_i, output/input, 1 each, FPU issue handshake.
REQ-011 SHALL have fpu_op_o (4), fpu_fmt_o (3), fpu_operands_o (3 x WIDTH), fpu_tag_o ($clog2(NREQ)) as outputs, the forwarded request.
REQ-012 SHALL have fpu_rvalid_i (1), fpu_rtag_i ($clog2(NREQ)), fpu_result_i (WIDTH), fpu_flags_i (5) as inputs, the FPU response.
REQ-013 SHALL have resp_valid_o (NREQ), resp_result_o (WIDTH), resp_flags_o (5) as outputs, the routed response; no backpressure.
REQ-014 SHALL have busy_o, output, 1, high when any operation is in flight or an issue is pending.

Function
REQ-015 SHALL arbitrate among valid requesters round-robin; pointer advances to winner+1 (mod NREQ) only on an accepted issue.
REQ-016 SHALL use FSM states IDLE and HOLD: IDLE->HOLD when fpu_valid_o=1 and fpu_ready_i=0; HOLD->IDLE on fpu_ready_i=1.
REQ-017 SHALL, in HOLD, keep grant, fpu_op_o, fpu_fmt_o, fpu_operands_o and fpu_tag_o stable; no re-arbitration.
REQ-018 SHALL assert req_ready_o[i] only for the granted requester, in the cycle fpu_valid_o and fpu_ready_i are both 1.
REQ-019 SHALL set fpu_tag_o to the granted requester index.
REQ-020 SHALL keep a counter of in-flight operations: +1 on issue handshake, -1 on fpu_rvalid_i; both in one cycle leave it unchanged.
REQ-021 SHALL deassert fpu_valid_o when the count equals MAX_OUTST, unless fpu_rvalid_i is 1 in that cycle.
REQ-022 SHALL treat DIV and SQRT (op 4,5) as exclusive: a divsqrt_busy flag sets on their issue and clears on the response carrying the stored tag while the flag is set.
REQ-023 SHALL mask DIV/SQRT requesters from arbitration while divsqrt_busy=1; other requesters remain eligible.
REQ-024 SHALL accept an illegal op (code 15) without forwarding it: req_ready_o[i]=1 for one cycle, then resp_valid_o[i]=1 next cycle, result 0, flags 5'b10000 (NV).
REQ-025 SHALL give an FPU response priority over an illegal-op response in the same cycle; the illegal-op response is delayed one cycle and its request is not acknowledged until then.
REQ-026 SHALL drive resp_valid_o[fpu_rtag_i], resp_result_o and resp_flags_o combinationally from fpu_rvalid_i, zero latency; other resp_valid_o bits are 0.
REQ-027 SHALL add zero cycles of issue latency: request valid in cycle N with fpu_ready_i=1 issues in cycle N.
REQ-028 SHALL ignore fpu_rvalid_i when the in-flight count is 0 (no underflow); the counter saturates at MAX_OUTST.

Reset
REQ-029 SHALL, on rst=1, immediately force FSM=IDLE, RR pointer=0, count=0, divsqrt_busy=0, and all of fpu_valid_o, req_ready_o, resp_valid_o and busy_o to 0.
REQ-030 SHALL discard in-flight operations on reset mid-operation; late FPU responses arriving when count=0 are dropped per REQ-028.

Verification
REQ-031 Both requesters issue ADD continuously, fpu_ready_i=1: grants alternate 0,1,0,1, tags match.
REQ-032 Req0 issues with fpu_ready_i low for 3 cycles, then req1 asserts: fpu_* stable for 3 cycles, req0 accepted on cycle 4, req1 is granted next.
REQ-033 Req0 issues DIV, then both request SQRT/ADD: req1 ADD is issued, req0 SQRT is blocked until the DIV response with tag 0, then issued.
REQ-034 MAX_OUTST=2 with no responses: a third issue is blocked; when fpu_rvalid_i=1, issue proceeds in the same cycle and count stays 2.
REQ-035 Req1 issues op=15: req_ready_o[1] pulses, and resp_valid_o[1]=1, flags=5'b10000 follow next cycle. Repeat with a colliding FPU response: the illegal-op response is delayed one cycle.
REQ-036 Assert rst with 2 operations in flight: all outputs read 0, and a subsequent stray fpu_rvalid_i produces no resp_valid_o.

Source files
------------

// File: rtl/cv32e41p_fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between NREQ requesters, with in-flight
// limiting, exclusive DIV/SQRT, tagged response routing and local illegal-op retirement.
module cv32e41p_fpu_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_OUTST = 2,
    parameter int WIDTH     = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req_valid_i,
    output logic [NREQ-1:0]                   req_ready_o,
    input  logic [NREQ-1:0][3:0]              req_op_i,
    input  logic [NREQ-1:0][2:0]              req_fmt_i,
    input  logic [NREQ-1:0][2:0][WIDTH-1:0]   req_operands_i,
    output logic                              fpu_valid_o,
    input  logic                              fpu_ready_i,
    output logic [3:0]                        fpu_op_o,
    output logic [2:0]                        fpu_fmt_o,
    output logic [2:0][WIDTH-1:0]             fpu_operands_o,
    output logic [$clog2(NREQ)-1:0]           fpu_tag_o,
    input  logic                              fpu_rvalid_i,
    input  logic [$clog2(NREQ)-1:0]           fpu_rtag_i,
    input  logic [WIDTH-1:0]                  fpu_result_i,
    input  logic [4:0]                        fpu_flags_i,
    output logic [NREQ-1:0]                   resp_valid_o,
    output logic [WIDTH-1:0]                  resp_result_o,
    output logic [4:0]                        resp_flags_o,
    output logic                              busy_o
);
    localparam int TW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_SQRT = 4'd5;
    localparam logic [3:0] OP_ILL  = 4'd15;

    typedef enum logic {IDLE, HOLD} state_e;

    function automatic logic is_divsqrt(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_SQRT);
    endfunction

    function automatic logic [TW-1:0] next_ptr(input logic [TW-1:0] idx);
        if (idx == TW'(NREQ - 1)) return '0;
        return idx + 1'b1;
    endfunction

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c, input logic inc,
                                               input logic dec);
        case ({inc, dec})
            2'b10:   return (c == CNT_MAX) ? c : c + 1'b1;
            2'b01:   return (c == '0) ? c : c - 1'b1;
            default: return c;
        endcase
    endfunction

    state_e                  state;
    logic [TW-1:0]           ptr;
    logic [CW-1:0]           cnt;
    logic                    dsq_busy;
    logic [TW-1:0]           dsq_tag;
    logic                    ill_pend;
    logic [TW-1:0]           ill_idx;
    logic [TW-1:0]           hold_idx;
    logic [3:0]              hold_op;
    logic [2:0]              hold_fmt;
    logic [2:0][WIDTH-1:0]   hold_opnds;

    logic                    resp_eff, dsq_clr, dsq_block, can_issue;
    logic [NREQ-1:0]         elig;
    logic [TW-1:0]           cand, win_idx, g_idx;
    logic                    win_found, win_ill, fv, issue, ill_acc;

    // A response is only real while something is in flight; strays after reset are dropped.
    assign resp_eff  = fpu_rvalid_i && (cnt != '0);
    assign dsq_clr   = dsq_busy && resp_eff && (fpu_rtag_i == dsq_tag);
    assign dsq_block = dsq_busy && !dsq_clr;
    assign can_issue = (cnt < CNT_MAX) || resp_eff;

    always_comb begin
        elig      = '0;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid_i[i]
                      && !(dsq_block && is_divsqrt(req_op_i[i]))
                      && !(ill_pend && (req_op_i[i] == OP_ILL));
        end
        for (int k = 0; k < NREQ; k++) begin
            cand = TW'((int'(ptr) + k) % NREQ);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_ill = (req_op_i[win_idx] == OP_ILL);

    always_comb begin
        if (state == HOLD) begin
            g_idx          = hold_idx;
            fpu_op_o       = hold_op;
            fpu_fmt_o      = hold_fmt;
            fpu_operands_o = hold_opnds;
            fv             = 1'b1;
        end else begin
            g_idx          = win_idx;
            fpu_op_o       = req_op_i[win_idx];
            fpu_fmt_o      = req_fmt_i[win_idx];
            fpu_operands_o = req_operands_i[win_idx];
            fv             = win_found && !win_ill && can_issue;
        end
    end

    assign fpu_tag_o   = g_idx;
    assign fpu_valid_o = fv && !rst;
    assign issue       = fpu_valid_o && fpu_ready_i;
    assign ill_acc     = !rst && (state == IDLE) && win_found && win_ill;

    always_comb begin
        req_ready_o = '0;
        if (issue || ill_acc) req_ready_o[g_idx] = 1'b1;
    end

    // FPU responses win the shared response bus; a pending illegal-op reply waits.
    always_comb begin
        resp_valid_o  = '0;
        resp_result_o = '0;
        resp_flags_o  = '0;
        if (resp_eff) begin
            resp_valid_o[fpu_rtag_i] = 1'b1;
            resp_result_o            = fpu_result_i;
            resp_flags_o             = fpu_flags_i;
        end else if (ill_pend) begin
            resp_valid_o[ill_idx] = 1'b1;
            resp_flags_o          = 5'b10000;
        end
    end

    assign busy_o = (cnt != '0) || (state == HOLD) || ill_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            dsq_busy <= 1'b0;
            dsq_tag  <= '0;
            ill_pend <= 1'b0;
            ill_idx  <= '0;
        end else begin
            case (state)
                IDLE: if (fpu_valid_o && !fpu_ready_i) state <= HOLD;
                HOLD: if (fpu_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (issue || ill_acc) ptr <= next_ptr(g_idx);
            cnt <= cnt_next(cnt, issue, resp_eff);
            if (issue && is_divsqrt(fpu_op_o)) begin
                dsq_busy <= 1'b1;
                dsq_tag  <= g_idx;
            end else if (dsq_clr) begin
                dsq_busy <= 1'b0;
            end
            if (ill_acc) begin
                ill_pend <= 1'b1;
                ill_idx  <= g_idx;
            end else if (ill_pend && !resp_eff) begin
                ill_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && fpu_valid_o && !fpu_ready_i) begin
            hold_idx   <= win_idx;
            hold_op    <= req_op_i[win_idx];
            hold_fmt   <= req_fmt_i[win_idx];
            hold_opnds <= req_operands_i[win_idx];
        end
    end

endmodule
